shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 97 +++++++++
 tb/tb_shift_add_multiplier.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier, one partial product per clock
module shift_add_multiplier #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Start,
    input  logic [WORD_LENGTH-1:0]     Multiplicand,
    input  logic [WORD_LENGTH-1:0]     Multiplier,
    output logic [2*WORD_LENGTH-1:0]   Product,
    output logic                       Busy,
    output logic                       Ready,
    output logic                       Clear_Out,
    output logic                       Load_Out
);

    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [PW-1:0]          mcand;
    logic [WORD_LENGTH-1:0] mplier;
    logic [PW-1:0]          acc;
    logic [CW-1:0]          count;
    logic [PW-1:0]          next_acc;

    always_comb begin
        next_acc = acc;
        if (mplier[0]) begin
            next_acc = acc + mcand;
        end
    end

    // Pulse outputs default low each cycle and are raised only on the edge entering their state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            Product   <= '0;
            Busy      <= 1'b0;
            Ready     <= 1'b0;
            Clear_Out <= 1'b0;
            Load_Out  <= 1'b0;
        end else begin
            Ready     <= 1'b0;
            Clear_Out <= 1'b0;
            Load_Out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand     <= {{WORD_LENGTH{1'b0}}, Multiplicand};
                        mplier    <= Multiplier;
                        acc       <= '0;
                        count     <= '0;
                        Busy      <= 1'b1;
                        Clear_Out <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    state <= CALC;
                end
                CALC: begin
                    acc    <= next_acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WORD_LENGTH - 1)) begin
                        Product  <= next_acc;
                        Ready    <= 1'b1;
                        Load_Out <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           Start = 1'b0;
    logic [W-1:0]   Multiplicand = '0;
    logic [W-1:0]   Multiplier = '0;
    logic [2*W-1:0] Product;
    logic           Busy;
    logic           Ready;
    logic           Clear_Out;
    logic           Load_Out;

    int             n_checks = 0;
    int             n_fail = 0;
    logic [2*W-1:0] prev_prod = '0;
    logic [2*W-1:0] dreg = 16'hFFFF;

    shift_add_multiplier #(.WORD_LENGTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Busy         (Busy),
        .Ready        (Ready),
        .Clear_Out    (Clear_Out),
        .Load_Out     (Load_Out)
    );

    always #5 clk = ~clk;

    // Downstream synchronous-clear data register fed by the multiplier.
    always @(posedge clk) begin
        if (Clear_Out)
            dreg <= '0;
        else if (Load_Out)
            dreg <= Product;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        logic [2*W-1:0] exp_p;
        exp_p = 16'(a) * 16'(b);
        @(negedge clk);
        Start = 1'b1;
        Multiplicand = a;
        Multiplier = b;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                Start = 1'b0;
                Multiplicand = W'($urandom);
                Multiplier = W'($urandom);
            end
            if (disturb && k == 4) begin
                Start = 1'b1;
                Multiplicand = 9;
                Multiplier = 9;
            end
            if (disturb && k == 5)
                Start = 1'b0;
            chk("busy", 32'(Busy), 32'(k <= LAT));
            chk("clear_out", 32'(Clear_Out), 32'(k == 1));
            chk("ready", 32'(Ready), 32'(k == LAT));
            chk("load_out", 32'(Load_Out), 32'(k == LAT));
            chk("product", 32'(Product), 32'((k >= LAT) ? exp_p : prev_prod));
            if (k == 2)
                chk("dreg_cleared", 32'(dreg), 32'(0));
            if (k == LAT + 1)
                chk("dreg_captured", 32'(dreg), 32'(exp_p));
        end
        prev_prod = exp_p;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_product", 32'(Product), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_ready", 32'(Ready), 0);
        chk("rst_clear_out", 32'(Clear_Out), 0);
        chk("rst_load_out", 32'(Load_Out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(8'd13, 8'd11, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd0, 8'd200, 1'b0);
        run_op(8'd1, 8'd128, 1'b0);

        run_op(8'd6, 8'd7, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_extra_ready", 32'(Ready), 0);
            chk("no_extra_busy", 32'(Busy), 0);
        end

        // Abort mid-CALC with an asynchronous reset.
        @(negedge clk);
        Start = 1'b1;
        Multiplicand = 200;
        Multiplier = 3;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_product", 32'(Product), 0);
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_ready", 32'(Ready), 0);
        chk("abort_clear_out", 32'(Clear_Out), 0);
        chk("abort_load_out", 32'(Load_Out), 0);
        prev_prod = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_abort_ready", 32'(Ready), 0);
            chk("post_abort_busy", 32'(Busy), 0);
        end
        run_op(8'd7, 8'd6, 1'b0);

        // Start held high: back-to-back operations with one idle cycle between.
        @(negedge clk);
        Start = 1'b1;
        Multiplicand = 5;
        Multiplier = 5;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) begin
                Multiplicand = 4;
                Multiplier = 3;
            end
            chk("held_ready", 32'(Ready), 32'(k == 10 || k == 21));
            chk("held_busy", 32'(Busy), 32'(k <= 10 || (k >= 12 && k <= 21)));
            chk("held_clear_out", 32'(Clear_Out), 32'(k == 1 || k == 12));
            chk("held_product", 32'(Product),
                (k < 10) ? 32'(prev_prod) : ((k < 21) ? 32'd25 : 32'd12));
            if (k == 21)
                Start = 1'b0;
        end
        prev_prod = 16'd12;

        for (int i = 0; i < 8; i++)
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
